// File: rtl/softmax_norm_sched_if.sv
// Stream bundle around the softmax divide sequencer: exp input, divide-unit issue/return, result output.
interface softmax_norm_sched_if #(
  parameter int DATA_W = 24
);
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              div_in_tvalid;
  logic              div_in_tready;
  logic [7:0]        divisor_exponent_tdata;
  logic [DATA_W-1:0] dividend_power_tdata;
  logic              div_out_tvalid;
  logic [15:0]       div_out_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [15:0]       m_tdata;
  logic              m_tlast;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, div_in_tready, div_out_tvalid, div_out_tdata, m_tready,
    output s_tready, div_in_tvalid, divisor_exponent_tdata, dividend_power_tdata,
           m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, div_in_tready, div_out_tvalid, div_out_tdata, m_tready,
    input  s_tready, div_in_tvalid, divisor_exponent_tdata, dividend_power_tdata,
           m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/softmax_norm_sched.sv
// Buffers and sums one exp vector, then replays it to the divide unit with the sum's biased exponent.
// First result 3 cycles after NORM; issue is credit-limited so the 2-entry result FIFO never overflows.
module softmax_norm_sched #(
  parameter int DATA_W   = 24,
  parameter int MAX_LEN  = 256,
  parameter int ADDR_W   = 8,
  parameter int SUM_W    = 32,
  parameter int EXP_BIAS = 16
) (
  input  logic                aclk,
  input  logic                rst_n,
  softmax_norm_sched_if.slave io,
  output logic                busy,
  output logic                err_overlen
);

  typedef enum logic [2:0] {IDLE, ACCUM, NORM, ISSUE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [MAX_LEN];
  logic [DATA_W-1:0] rd_dat;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0]   count, rd_ptr, res_cnt;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W:0]    sum_add;
  logic [7:0]        lead, exp_nxt, exp_reg;
  logic [1:0]        inflight, fifo_cnt;
  logic [15:0]       f_dat [2];
  logic [1:0]        f_last;
  logic              wp, rp;
  logic              in_hs, at_max, credit, issue, issue_last, res_ok, last_tag, pop;

  assign in_hs      = io.s_tvalid && io.s_tready;
  assign at_max     = (count == (ADDR_W+1)'(MAX_LEN-1));
  assign credit     = (({1'b0, fifo_cnt} + {1'b0, inflight}) < 3'd2);
  assign issue_last = (rd_ptr == count - (ADDR_W+1)'(1));
  assign res_ok     = io.div_out_tvalid && (inflight != 2'd0);
  assign last_tag   = (res_cnt == count - (ADDR_W+1)'(1));
  assign pop        = io.m_tvalid && io.m_tready;
  assign sum_add    = {1'b0, sum} + (SUM_W+1)'(io.s_tdata);
  assign wr_addr    = (state == IDLE) ? '0 : count[ADDR_W-1:0];
  assign busy       = (state != IDLE);

  assign io.div_in_tvalid          = issue;
  assign io.divisor_exponent_tdata = exp_reg;
  assign io.dividend_power_tdata   = rd_dat;
  assign io.m_tvalid               = (fifo_cnt != 2'd0);
  assign io.m_tdata                = f_dat[rp];
  assign io.m_tlast                = f_last[rp];

  always_comb begin
    lead = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum[i]) lead = 8'(i);
    end
    exp_nxt = (sum == '0) ? 8'h80 : lead - 8'(EXP_BIAS);
  end

  // Prefetch the next element on issue so dividend always equals buf[rd_ptr].
  always_comb begin
    rd_addr = rd_ptr[ADDR_W-1:0];
    if (state == NORM) rd_addr = '0;
    else if (issue)    rd_addr = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
  end

  always_comb begin
    state_nxt   = state;
    io.s_tready = 1'b0;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        io.s_tready = 1'b1;
        if (io.s_tvalid) state_nxt = io.s_tlast ? NORM : ACCUM;
      end
      ACCUM: begin
        io.s_tready = 1'b1;
        if (io.s_tvalid && (io.s_tlast || at_max)) state_nxt = NORM;
      end
      NORM:  state_nxt = ISSUE;
      ISSUE: begin
        issue = io.div_in_tready && credit;
        if (issue && issue_last) state_nxt = DRAIN;
      end
      DRAIN: if (inflight == 2'd0 && fifo_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (in_hs) mem[wr_addr] <= io.s_tdata;
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      sum         <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      res_cnt     <= '0;
      exp_reg     <= '0;
      rd_dat      <= '0;
      inflight    <= '0;
      fifo_cnt    <= '0;
      f_dat[0]    <= '0;
      f_dat[1]    <= '0;
      f_last      <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      err_overlen <= 1'b0;
      if (in_hs) begin
        if (state == IDLE) begin
          sum   <= SUM_W'(io.s_tdata);
          count <= (ADDR_W+1)'(1);
        end else begin
          sum         <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
          count       <= count + (ADDR_W+1)'(1);
          err_overlen <= at_max && !io.s_tlast;
        end
      end
      if (state == NORM) begin
        exp_reg <= exp_nxt;
        rd_ptr  <= '0;
        res_cnt <= '0;
      end
      if (issue) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      if (state == NORM || state == ISSUE) rd_dat <= mem[rd_addr];

      case ({issue, res_ok})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: ;
      endcase

      if (res_ok) begin
        f_dat[wp]  <= io.div_out_tdata;
        f_last[wp] <= last_tag;
        wp         <= ~wp;
        res_cnt    <= res_cnt + (ADDR_W+1)'(1);
      end
      if (pop) rp <= ~rp;
      case ({res_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
